// File: rtl/blit_src_reader_if.sv
// rtl/blit_src_reader_if.sv - command, cache-read and pixel-stream bundle of the blitter source reader
interface blit_src_reader_if #(
    parameter int COORD_W = 11
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [31:0]        cmd_src_addr;
    logic [15:0]        cmd_stride;
    logic [COORD_W-1:0] cmd_width;
    logic [COORD_W-1:0] cmd_height;

    logic [31:0]        read_address;
    logic               read_request;
    logic               read_stall;
    logic [7:0]         read_data;
    logic               read_valid;

    logic               pix_valid;
    logic               pix_ready;
    logic [7:0]         pix_data;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic               pix_last;
    logic               busy;

    // master: command issuer, read cache and pixel consumer; slave: the reader itself
    modport master (
        output cmd_valid, cmd_src_addr, cmd_stride, cmd_width, cmd_height,
        input  cmd_ready,
        input  read_address, read_request,
        output read_stall, read_data, read_valid,
        input  pix_valid, pix_data, pix_x, pix_y, pix_last, busy,
        output pix_ready
    );

    modport slave (
        input  cmd_valid, cmd_src_addr, cmd_stride, cmd_width, cmd_height,
        output cmd_ready,
        output read_address, read_request,
        input  read_stall, read_data, read_valid,
        output pix_valid, pix_data, pix_x, pix_y, pix_last, busy,
        input  pix_ready
    );
endinterface

// File: rtl/blit_src_reader.sv
// rtl/blit_src_reader.sv - walks a source rectangle, issues byte reads and tags returned bytes with (x,y)
module blit_src_reader #(
    parameter int COORD_W    = 11,
    parameter int FIFO_DEPTH = 3
) (
    input logic               clock,
    input logic               reset,
    blit_src_reader_if.slave  bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    typedef struct packed {
        logic [7:0]         data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               last;
    } entry_t;

    state_t             state_q;
    logic               cmd_ready_q;
    logic               busy_q;
    logic [COORD_W-1:0] width_q;
    logic [COORD_W-1:0] height_q;
    logic [15:0]        stride_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [31:0]        row_base_q;
    logic               inflight_q;
    logic [COORD_W-1:0] tag_x_q;
    logic [COORD_W-1:0] tag_y_q;
    logic               tag_last_q;
    entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic   row_end;
    logic   last_req;
    logic   accept;
    logic   push;
    logic   pop;
    entry_t head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit counts the in-flight byte so the FIFO can never overflow and pix_ready never reaches the request.
    assign bus.read_request = (state_q == ISSUE) && ((32'(count_q) + 32'(inflight_q)) < FIFO_DEPTH);
    assign bus.read_address = row_base_q + 32'(x_q);
    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.busy         = busy_q;

    assign row_end  = (x_q == width_q - COORD_W'(1));
    assign last_req = row_end && (y_q == height_q - COORD_W'(1));
    assign accept   = bus.read_request && !bus.read_stall;
    // read_valid stays high through cache stalls, so only the slot after an acceptance carries data
    assign push     = inflight_q && bus.read_valid;
    assign head     = fifo_q[rd_ptr_q];
    assign pop      = bus.pix_valid && bus.pix_ready;

    assign bus.pix_valid = (count_q != '0);
    assign bus.pix_data  = head.data;
    assign bus.pix_x     = head.x;
    assign bus.pix_y     = head.y;
    assign bus.pix_last  = bus.pix_valid && head.last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            width_q     <= '0;
            height_q    <= '0;
            stride_q    <= '0;
            x_q         <= '0;
            y_q         <= '0;
            row_base_q  <= '0;
            inflight_q  <= 1'b0;
            tag_x_q     <= '0;
            tag_y_q     <= '0;
            tag_last_q  <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                tag_x_q    <= x_q;
                tag_y_q    <= y_q;
                tag_last_q <= last_req;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= '{data: bus.read_data, x: tag_x_q, y: tag_y_q, last: tag_last_q};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);

            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        width_q    <= bus.cmd_width;
                        height_q   <= bus.cmd_height;
                        stride_q   <= bus.cmd_stride;
                        row_base_q <= bus.cmd_src_addr;
                        x_q        <= '0;
                        y_q        <= '0;
                        // An empty rectangle completes on the spot
                        if (bus.cmd_width != '0 && bus.cmd_height != '0) begin
                            state_q     <= ISSUE;
                            cmd_ready_q <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        if (row_end) begin
                            x_q        <= '0;
                            y_q        <= y_q + COORD_W'(1);
                            row_base_q <= row_base_q + {16'b0, stride_q};
                        end else begin
                            x_q <= x_q + COORD_W'(1);
                        end
                        if (last_req) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && head.last) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    a_return_valid: assert property (@(posedge clock) disable iff (reset) inflight_q |-> bus.read_valid);
    a_no_overflow:  assert property (@(posedge clock) disable iff (reset)
                                     push |-> (count_q != CNT_W'(FIFO_DEPTH)));
endmodule

// File: tb/tb_blit_src_reader.sv
// tb/tb_blit_src_reader.sv - scoreboard bench for blit_src_reader with a byte-memory cache model
module tb_blit_src_reader;
    localparam int CW = 11;

    logic clock = 1'b0;
    logic reset = 1'b1;

    blit_src_reader_if #(.COORD_W(CW)) bus ();

    blit_src_reader #(.COORD_W(CW), .FIFO_DEPTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] exp_addr[$];
    logic [30:0] exp_pix[$];
    int acc_cyc[$];
    int pop_cyc[$];
    bit rand_stall   = 0;
    bit rand_ready   = 0;
    bit stall2       = 0;
    int n_acc        = 0;
    int stall_cnt    = 0;
    int ready_low_at = -1;
    int ready_low_cnt = 0;
    int low_end_cyc  = -1;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ {a[12:8], a[15:13]} ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Reference: every pixel of the rectangle in row-major order, address by plain arithmetic
    task automatic build_expect(input logic [31:0] src, input logic [15:0] stride, input int w, input int h);
        logic [31:0] a;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                a = src + 32'(y) * 32'(stride) + 32'(x);
                exp_addr.push_back(a);
                exp_pix.push_back({mem_byte(a), CW'(x), CW'(y), (x == w - 1) && (y == h - 1)});
            end
        end
    endtask

    // Request monitor: address must match the next expected one on every presenting cycle
    always @(negedge clock) begin
        if (!reset && bus.read_request) begin
            if (exp_addr.size() == 0) fail_now("unexpected_request");
            else begin
                check("read_address", bus.read_address, exp_addr[0]);
                if (!bus.read_stall) begin
                    void'(exp_addr.pop_front());
                    acc_cyc.push_back(cyc);
                end
            end
        end
    end

    // Pixel monitor
    always @(negedge clock) begin
        if (!reset && bus.pix_valid && bus.pix_ready) begin
            if (exp_pix.size() == 0) fail_now("extra_pixel");
            else check("pixel{data,x,y,last}", {bus.pix_data, bus.pix_x, bus.pix_y, bus.pix_last},
                       exp_pix.pop_front());
            pop_cyc.push_back(cyc);
        end
    end

    // Read cache: data one cycle after acceptance, read_valid held across stall cycles
    initial begin
        logic acc_l;
        logic [31:0] addr_l;
        bus.read_stall = 1'b0;
        bus.read_valid = 1'b0;
        bus.read_data  = 8'h00;
        forever begin
            @(negedge clock);
            acc_l  = bus.read_request && !bus.read_stall;
            addr_l = bus.read_address;
            if (acc_l) begin
                n_acc++;
                if (stall2 && n_acc == 1) stall_cnt = 5;
            end
            @(posedge clock);
            #1;
            if (acc_l) begin
                bus.read_valid = 1'b1;
                bus.read_data  = mem_byte(addr_l);
            end else if (!bus.read_stall) begin
                bus.read_valid = 1'b0;
                bus.read_data  = 8'($urandom);
            end
            if (stall_cnt > 0) begin
                bus.read_stall = 1'b1;
                stall_cnt--;
            end else begin
                bus.read_stall = rand_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    end

    // Pixel consumer
    initial begin
        bus.pix_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            if (ready_low_at >= 0 && pop_cyc.size() >= ready_low_at) begin
                ready_low_cnt = 10;
                ready_low_at  = -1;
            end
            if (ready_low_cnt > 0) begin
                bus.pix_ready = 1'b0;
                ready_low_cnt--;
                if (ready_low_cnt == 0) begin
                    @(negedge clock);
                    check("request_dropped_fifo_full", bus.read_request, 1'b0);
                    check("fifo_head_valid_while_blocked", bus.pix_valid, 1'b1);
                    low_end_cyc = cyc;
                end
            end else begin
                bus.pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    task automatic issue_cmd(input logic [31:0] src, input logic [15:0] stride, input int w, input int h);
        @(posedge clock);
        #1;
        build_expect(src, stride, w, h);
        acc_cyc.delete();
        pop_cyc.delete();
        n_acc = 0;
        bus.cmd_valid    = 1'b1;
        bus.cmd_src_addr = src;
        bus.cmd_stride   = stride;
        bus.cmd_width    = CW'(w);
        bus.cmd_height   = CW'(h);
        @(negedge clock);
        check("cmd_ready_at_issue", bus.cmd_ready, 1'b1);
        @(posedge clock);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input logic [31:0] src, input logic [15:0] stride, input int w, input int h);
        int guard;
        issue_cmd(src, stride, w, h);
        if (w == 0 || h == 0) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check("empty_cmd_ready", bus.cmd_ready, 1'b1);
                check("empty_cmd_no_request", bus.read_request, 1'b0);
                check("empty_cmd_no_pixel", bus.pix_valid, 1'b0);
            end
        end else begin
            guard = 0;
            do begin
                @(negedge clock);
                guard++;
            end while (!bus.cmd_ready && guard < 3000);
            check("cmd_completes", guard < 3000, 1'b1);
            if (pop_cyc.size() == 0) fail_now("no_pixels_popped");
            else check("cmd_ready_one_after_last_pop", cyc - pop_cyc[$], 1);
            check("busy_clear_at_done", bus.busy, 1'b0);
            check("all_addresses_issued", exp_addr.size(), 0);
            check("all_pixels_delivered", exp_pix.size(), 0);
        end
    endtask

    initial begin
        int guard;
        int k;
        bus.cmd_valid    = 1'b0;
        bus.cmd_src_addr = '0;
        bus.cmd_stride   = '0;
        bus.cmd_width    = '0;
        bus.cmd_height   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_cmd_ready", bus.cmd_ready, 1'b1);
        check("reset_read_request", bus.read_request, 1'b0);
        check("reset_read_address", bus.read_address, 32'h0);
        check("reset_pix_valid", bus.pix_valid, 1'b0);
        check("reset_pix_last", bus.pix_last, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic 4x2 with full throughput
        run_cmd(32'h0000_0100, 16'd320, 4, 2);
        check("basic_accept_count", acc_cyc.size(), 8);
        if (acc_cyc.size() == 8 && pop_cyc.size() == 8) begin
            check("first_pixel_latency", pop_cyc[0] - acc_cyc[0], 2);
            check("requests_back_to_back", acc_cyc[7] - acc_cyc[0], 7);
            check("pixels_back_to_back", pop_cyc[7] - pop_cyc[0], 7);
        end

        // 5-cycle stall on the second request with read_valid held high
        stall2 = 1;
        run_cmd(32'h0000_0100, 16'd320, 4, 2);
        stall2 = 0;
        check("stall_pixel_count", pop_cyc.size(), 8);

        // Consumer blocked for 10 cycles mid-row
        ready_low_at = 4;
        run_cmd(32'h0000_2000, 16'd64, 16, 2);
        k = 0;
        while (k < pop_cyc.size() && pop_cyc[k] <= low_end_cyc) k++;
        check("resume_pixels_seen", k < pop_cyc.size(), 1'b1);
        if (k < pop_cyc.size()) check("resume_one_per_clock", pop_cyc[$] - pop_cyc[k], pop_cyc.size() - 1 - k);

        // Empty rectangle, then single pixel in pattern memory
        run_cmd(32'h0000_4000, 16'd8, 0, 5);
        run_cmd(32'hE100_0010, 16'd1, 1, 1);

        // Address wrap
        run_cmd(32'hFFFF_FFFE, 16'd100, 4, 1);

        // Reset during row 1 of a 16x16 blit
        issue_cmd(32'h0001_0000, 16'd512, 16, 16);
        guard = 0;
        while (acc_cyc.size() < 20 && guard < 1000) begin
            @(negedge clock);
            guard++;
        end
        check("reached_row_1", acc_cyc.size() >= 20, 1'b1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        exp_addr.delete();
        exp_pix.delete();
        @(negedge clock);
        check("post_reset_pix_valid", bus.pix_valid, 1'b0);
        check("post_reset_read_request", bus.read_request, 1'b0);
        check("post_reset_cmd_ready", bus.cmd_ready, 1'b1);
        run_cmd(32'h0000_3000, 16'd10, 2, 1);
        check("post_reset_pixel_count", pop_cyc.size(), 2);

        // Randomised commands with random stalls and backpressure
        rand_stall = 1;
        rand_ready = 1;
        for (int i = 0; i < 8; i++)
            run_cmd($urandom, 16'($urandom), $urandom_range(1, 7), $urandom_range(1, 4));
        rand_stall = 0;
        rand_ready = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/blit_src_reader.md
Name: blit_src_reader

Overview:
Upstream source-fetch stage of the blitter. Accepts one rectangle-read command. Walks the source rectangle row-major and issues byte read requests to the blitter read cache (the cache/pattern-memory front end). Re-associates each returned byte with its (x,y) coordinate and delivers it, with backpressure, to the blitter pixel pipeline through a 3-entry output FIFO.

Parameters:
COORD_W, 11, width of width/height/x/y fields (max 2047 pixels per axis)
FIFO_DEPTH, 3, output FIFO depth; fixed at 3, the minimum for full throughput without a combinational path from pix_ready to read_request

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_src_addr  in  32  byte address of pixel (0,0); may target main memory or pattern memory 0xE100xxxx
cmd_stride  in  16  unsigned byte pitch between rows
cmd_width  in  COORD_W  pixels per row
cmd_height  in  COORD_W  rows
read_address  out  32  byte address to cache
read_request  out  1  request valid
read_stall  in  1  cache cannot accept this cycle
read_data  in  8  returned byte
read_valid  in  1  cache data-valid flag
pix_valid  out  1  FIFO head valid
pix_ready  in  1  downstream accepts
pix_data  out  8  source byte
pix_x  out  COORD_W  column of pixel
pix_y  out  COORD_W  row of pixel
pix_last  out  1  final pixel of command
busy  out  1  state != IDLE

Behaviour:
- Reset values: cmd_ready=1, read_request=0, read_address=0, pix_valid=0, pix_last=0, busy=0. FIFO is empty and in-flight flag is cleared. Reset mid-blit abandons the command; any byte returned after reset is discarded.
- States:
  - IDLE: cmd_valid&&cmd_ready latches the command. If width==0 or height==0, stay IDLE; no pixels are produced and the command completes immediately. Otherwise go to ISSUE with x=0, y=0, row_base=cmd_src_addr.
  - ISSUE: generate requests. After the final request is accepted, go to DRAIN.
  - DRAIN: when the pix_last entry is popped, return to IDLE.
- Address: read_address = row_base + x, 32-bit modulo 2^32.
  - At end of row (x==width-1): x←0, y←y+1, row_base←row_base+zero-extended stride.
- Acceptance: a request is accepted in a cycle where read_request && !read_stall.
  - While stalled, read_request and read_address are held stable. No new address is presented until acceptance.
- Credit rule: read_request = (state==ISSUE) && (fifo_count + inflight < 3). It is registered/derived from state only, never from pix_ready.
- Return qualification:
  - inflight ← accepted (1-cycle delayed flag).
  - The cache returns data exactly one cycle after acceptance.
  - A byte is pushed only when inflight && read_valid.
  - read_valid alone is not trusted: the cache holds read_valid high across its stall cycles, and counting it would duplicate pixels.
  - inflight && !read_valid is a protocol error; flag it via $display in simulation.
- Tag pipe: {x, y, last} registered at acceptance and pushed together with read_data.
- FIFO: push and pop in the same cycle is allowed; count is unchanged.
  - Pop = pix_valid && pix_ready. Outputs are the FIFO head.
  - Overflow is impossible by the credit rule; assert on push-when-full.
- Throughput: 1 pixel/clock when there are no stalls and pix_ready=1. First pix_valid appears 2 cycles after the first acceptance.
- busy stays high until the last pixel is popped.

Test Plan:
- 4x2 blit, src=0x00000100, stride=320 -> addresses 0x100,0x101,0x102,0x103,0x240,0x241,0x242,0x243 in order; pixels tagged (0,0)..(3,1); pix_last only on (3,1); cmd_ready high 1 cycle after final pop.
- read_stall high 5 cycles on 2nd request (read_valid held high meanwhile) -> read_address held at 0x101 throughout, exactly 8 pixels total, no duplicates, data matches memory model.
- pix_ready low 10 cycles mid-row -> FIFO reaches 3, read_request drops, no pixel lost or reordered; 1 pixel/clock resumes after pix_ready returns.
- width=0, height=5 -> no read_request, no pix_valid, cmd_ready high again next cycle; then width=1, height=1 at 0xE1000010 -> single request 0xE1000010, pix_last=1.
- src=0xFFFFFFFE, width=4, height=1 -> addresses 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001.
- reset asserted during row 1 of a 16x16 blit -> next cycle: pix_valid=0, read_request=0, cmd_ready=1; a following 2x1 command produces exactly 2 correct pixels.
